// File: rtl/tube_bcd_writer.sv
// Converts a 27-bit binary value to 8 BCD digits (double-dabble) and writes it to a
// digital-tube peripheral as three held register writes: low digits, high digits, blanking/dp.
module tube_bcd_writer #(
  parameter int HOLD_CYCLES = 64
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [26:0] value_in,
  input  logic [7:0]  dp_in,
  output logic        busy,
  output logic        done,
  output logic        overflow,
  output logic        tube_write_enable,
  output logic        tube_ctrl,
  output logic [2:0]  tube_address,
  output logic [15:0] tube_data
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CONVERT = 3'd1,
    MASK    = 3'd2,
    WR_LOW  = 3'd3,
    WR_HIGH = 3'd4,
    WR_SPEC = 3'd5,
    DONE    = 3'd6
  } state_t;

  localparam logic [7:0]  HOLD_RELOAD = 8'(HOLD_CYCLES - 1);
  localparam logic [26:0] BCD_MAX     = 27'd99999999;
  localparam logic [4:0]  LAST_BIT    = 5'd26;

  // One double-dabble step: add 3 to every nibble >= 5, then shift in the next source bit.
  function automatic logic [31:0] dabble_step(input logic [31:0] bcd, input logic src_bit);
    logic [31:0] adj;
    for (int i = 0; i < 8; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) begin
        adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
      end else begin
        adj[4*i +: 4] = bcd[4*i +: 4];
      end
    end
    return {adj[30:0], src_bit};
  endfunction

  // Digit i is lit when it or any more significant digit is nonzero; digit 0 is always lit.
  function automatic logic [7:0] digit_mask(input logic [31:0] bcd);
    logic [7:0] en;
    logic       seen;
    seen = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      if (bcd[4*i +: 4] != 4'd0) begin
        seen = 1'b1;
      end else begin
        seen = seen;
      end
      en[i] = seen | (i == 0);
    end
    return en;
  endfunction

  state_t      state_r, next_state_s;
  logic [26:0] bin_r;
  logic [31:0] bcd_r;
  logic [7:0]  dp_r;
  logic [7:0]  enable_r;
  logic [4:0]  bit_cnt_r;
  logic [7:0]  hold_r;
  logic        overflow_r;
  logic        busy_r;
  logic        done_r;
  logic        tube_we_r;
  logic        tube_ctrl_r;
  logic [2:0]  tube_addr_r;
  logic [15:0] tube_data_r;

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic; timed states advance on their internal counters only.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          next_state_s = CONVERT;
        end else begin
          next_state_s = IDLE;
        end
      end
      CONVERT: begin
        if (bit_cnt_r == LAST_BIT) begin
          next_state_s = MASK;
        end else begin
          next_state_s = CONVERT;
        end
      end
      MASK: next_state_s = WR_LOW;
      WR_LOW: begin
        if (hold_r == 8'd0) begin
          next_state_s = WR_HIGH;
        end else begin
          next_state_s = WR_LOW;
        end
      end
      WR_HIGH: begin
        if (hold_r == 8'd0) begin
          next_state_s = WR_SPEC;
        end else begin
          next_state_s = WR_HIGH;
        end
      end
      WR_SPEC: begin
        if (hold_r == 8'd0) begin
          next_state_s = DONE;
        end else begin
          next_state_s = WR_SPEC;
        end
      end
      DONE:    next_state_s = IDLE;
      default: next_state_s = IDLE;
    endcase
  end

  // Request capture, conversion, mask and hold-counter datapath.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      bin_r      <= 27'd0;
      bcd_r      <= 32'd0;
      dp_r       <= 8'd0;
      enable_r   <= 8'd0;
      bit_cnt_r  <= 5'd0;
      hold_r     <= 8'd0;
      overflow_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            bin_r      <= (value_in > BCD_MAX) ? BCD_MAX : value_in;
            overflow_r <= (value_in > BCD_MAX);
            dp_r       <= dp_in;
            bcd_r      <= 32'd0;
            bit_cnt_r  <= 5'd0;
          end
        end
        CONVERT: begin
          bcd_r     <= dabble_step(bcd_r, bin_r[26]);
          bin_r     <= {bin_r[25:0], 1'b0};
          bit_cnt_r <= bit_cnt_r + 5'd1;
        end
        MASK: begin
          enable_r <= digit_mask(bcd_r);
          hold_r   <= HOLD_RELOAD;
        end
        WR_LOW, WR_HIGH, WR_SPEC: begin
          // Reload on expiry so the next write window starts with a full count.
          if (hold_r == 8'd0) begin
            hold_r <= HOLD_RELOAD;
          end else begin
            hold_r <= hold_r - 8'd1;
          end
        end
        default: begin
          hold_r <= hold_r;
        end
      endcase
    end
  end

  // Registered outputs decoded from the next state, so the bus changes only at window edges.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      tube_we_r   <= 1'b0;
      tube_ctrl_r <= 1'b0;
      tube_addr_r <= 3'b000;
      tube_data_r <= 16'd0;
    end else begin
      busy_r <= (next_state_s != IDLE);
      done_r <= (next_state_s == DONE);
      case (next_state_s)
        WR_LOW: begin
          tube_we_r   <= 1'b1;
          tube_ctrl_r <= 1'b1;
          tube_addr_r <= 3'b000;
          tube_data_r <= bcd_r[15:0];
        end
        WR_HIGH: begin
          tube_we_r   <= 1'b1;
          tube_ctrl_r <= 1'b1;
          tube_addr_r <= 3'b010;
          tube_data_r <= bcd_r[31:16];
        end
        WR_SPEC: begin
          tube_we_r   <= 1'b1;
          tube_ctrl_r <= 1'b1;
          tube_addr_r <= 3'b100;
          tube_data_r <= {enable_r, dp_r};
        end
        default: begin
          tube_we_r   <= 1'b0;
          tube_ctrl_r <= 1'b0;
          tube_addr_r <= 3'b000;
          tube_data_r <= 16'd0;
        end
      endcase
    end
  end

  assign busy              = busy_r;
  assign done              = done_r;
  assign overflow          = overflow_r;
  assign tube_write_enable = tube_we_r;
  assign tube_ctrl         = tube_ctrl_r;
  assign tube_address      = tube_addr_r;
  assign tube_data         = tube_data_r;

endmodule
